// File: rtl/rcc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rcc_pkg
// Description : Source encodings, FSM state type and helpers shared by the
//               system clock switch controller.
// Revision    : 1.0
// ============================================================================
package rcc_pkg;

    localparam logic [1:0] SRC_HSI  = 2'd0;
    localparam logic [1:0] SRC_CSI  = 2'd1;
    localparam logic [1:0] SRC_HSE  = 2'd2;
    localparam logic [1:0] SRC_PLL1 = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_WAIT_RDY = 2'd1;
    localparam state_t ST_SETTLE   = 2'd2;

    function automatic logic [3:0] src_onehot(input logic [1:0] src);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[src] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rcc_sw_timer.sv
`default_nettype none
// ============================================================================
// Module      : rcc_sw_timer
// Description : Loadable saturating down-counter with zero flag.
// Revision    : 1.0
// ============================================================================
module rcc_sw_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/rcc_sys_clk_sw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rcc_sys_clk_sw_ctrl
// Description : Select/status control for the glitch-free sys_clk switch,
//               including CSS and stop-wakeup forced switches.
// Revision    : 1.0
// ============================================================================
module rcc_sys_clk_sw_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int RDY_TIMEOUT   = 1024
) (
    input  logic       clk_in,
    input  logic       sys_rst,
    input  logic       sw_wr,
    input  logic [1:0] sw_req,
    input  logic       hsi_rdy,
    input  logic       csi_rdy,
    input  logic       hse_rdy,
    input  logic       pll1_rdy,
    input  logic       stop_wakeup,
    input  logic       stopwuck,
    input  logic       hse_css_fail,
    output logic [1:0] sys_clk_sw,
    output logic [1:0] sws,
    output logic       sw_busy,
    output logic       sw_err,
    output logic       css_evt,
    output logic [3:0] src_in_use
);

    import rcc_pkg::*;

    localparam int c_SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_TO_W  = (RDY_TIMEOUT > 1)   ? $clog2(RDY_TIMEOUT)   : 1;
    localparam logic [c_SET_W-1:0] c_SET_LOAD = c_SET_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LOAD  = c_TO_W'(RDY_TIMEOUT - 1);

    state_t     r_state;
    logic [1:0] r_target;
    logic [1:0] r_sys_clk_sw;
    logic [1:0] r_sws;
    logic       r_sw_busy;
    logic       r_sw_err;
    logic       r_css_evt;

    logic       w_tgt_rdy;
    logic       w_css_hit;
    logic       w_force;
    logic [1:0] w_force_src;
    logic       w_accept;
    logic       w_rdy_sw;
    logic       w_set_load;
    logic       w_set_dec;
    logic       w_set_zero;
    logic       w_to_dec;
    logic       w_to_zero;

    always_comb begin
        w_tgt_rdy = 1'b0;
        case (r_target)
            SRC_HSI:  w_tgt_rdy = hsi_rdy;
            SRC_CSI:  w_tgt_rdy = csi_rdy;
            SRC_HSE:  w_tgt_rdy = hse_rdy;
            SRC_PLL1: w_tgt_rdy = pll1_rdy;
            default:  w_tgt_rdy = 1'b0;
        endcase
    end

    // Bit 1 of the encoding marks the HSE-derived sources (HSE, PLL1).
    assign w_css_hit   = hse_css_fail && (r_sws[1] || r_sys_clk_sw[1]);
    assign w_force     = w_css_hit || stop_wakeup;
    assign w_force_src = (w_css_hit || !stopwuck) ? SRC_HSI : SRC_CSI;

    assign w_accept   = sw_wr && (r_state == ST_IDLE) && (sw_req != r_sws) && !w_force;
    assign w_rdy_sw   = (r_state == ST_WAIT_RDY) && w_tgt_rdy && !w_force;
    assign w_set_load = w_force || w_rdy_sw;
    assign w_set_dec  = (r_state == ST_SETTLE);
    assign w_to_dec   = (r_state == ST_WAIT_RDY) && !w_tgt_rdy && !w_force;

    rcc_sw_timer #(.WIDTH(c_SET_W)) u_settle_tmr (
        .clk        (clk_in),
        .rst        (sys_rst),
        .i_load     (w_set_load),
        .i_load_val (c_SET_LOAD),
        .i_dec      (w_set_dec),
        .o_zero     (w_set_zero)
    );

    rcc_sw_timer #(.WIDTH(c_TO_W)) u_timeout_tmr (
        .clk        (clk_in),
        .rst        (sys_rst),
        .i_load     (w_accept),
        .i_load_val (c_TO_LOAD),
        .i_dec      (w_to_dec),
        .o_zero     (w_to_zero)
    );

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            r_state      <= ST_IDLE;
            r_target     <= SRC_HSI;
            r_sys_clk_sw <= SRC_HSI;
            r_sws        <= SRC_HSI;
            r_sw_busy    <= 1'b0;
            r_sw_err     <= 1'b0;
            r_css_evt    <= 1'b0;
        end else begin
            r_css_evt <= w_css_hit;
            if (w_force) begin
                r_sys_clk_sw <= w_force_src;
                r_state      <= ST_SETTLE;
                r_sw_busy    <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_target  <= sw_req;
                            r_sw_err  <= 1'b0;
                            r_state   <= ST_WAIT_RDY;
                            r_sw_busy <= 1'b1;
                        end
                    end
                    ST_WAIT_RDY: begin
                        if (w_tgt_rdy) begin
                            r_sys_clk_sw <= r_target;
                            r_state      <= ST_SETTLE;
                        end else if (w_to_zero) begin
                            r_sw_err  <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_sw_busy <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (w_set_zero) begin
                            r_sws     <= r_sys_clk_sw;
                            r_sw_busy <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_sw_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sys_clk_sw = r_sys_clk_sw;
    assign sws        = r_sws;
    assign sw_busy    = r_sw_busy;
    assign sw_err     = r_sw_err;
    assign css_evt    = r_css_evt;
    assign src_in_use = src_onehot(r_sws) | (r_sw_busy ? src_onehot(r_sys_clk_sw) : 4'b0000);

endmodule
`default_nettype wire
